// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame geometry, common to
// the sender and the future receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: emits a one-cycle tick every DIV clocks while clear is low.
// The counter runs 0..DIV-1 and wraps on the tick, so it never overflows.
module uart_baud_tick #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = !clear && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_sender.sv
// 8N1 UART transmitter: FSM, shift register and registered line output;
// bit timing comes from uart_baud_tick.
//
// state | meaning
// IDLE  | line high, waiting for TX_EN; baud counter held at zero
// START | start bit (0) for one bit period
// DATA  | 8 data bits, LSB first, one bit period each
// STOP  | stop bit (1) for one bit period, then back to IDLE
module uart_sender
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       TX_EN,
  input  logic [7:0] TX_DATA,
  output logic       TX_STATUS,
  output logic       UART_TX
);

  localparam int DIV = CLK_FREQ / BAUD;

  uart_state_t          state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_idx;
  logic                 tx_line;
  logic                 tick;
  logic                 clear;

  // Holding the counter clear in IDLE restarts it at acceptance, so the start
  // bit gets a full period like every other bit.
  assign clear     = (state == IDLE);
  assign TX_STATUS = (state != IDLE);
  assign UART_TX   = tx_line;

  uart_baud_tick #(.DIV(DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      tx_line <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_line <= 1'b1;
          if (TX_EN) begin
            shreg   <= TX_DATA;
            bit_idx <= '0;
            tx_line <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_line <= shreg[0];
            shreg   <= shreg >> 1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              tx_line <= 1'b1;
              state   <= STOP;
            end else begin
              tx_line <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        STOP: begin
          tx_line <= 1'b1;
          if (tick) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sender.sv
// Directed bench for uart_sender: table of frames at DIV=16 plus hand-written
// reset, back-to-back and default-parameter sequences.
module tb_uart_sender;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_status;
  logic       uart_tx;

  logic       tx_en2;
  logic [7:0] tx_data2;
  logic       tx_status2;
  logic       uart_tx2;

  int n_checks = 0;
  int n_err    = 0;

  logic line_s [0:511];
  logic stat_s [0:511];

  typedef struct {
    logic [7:0] data;
    logic [0:9] pattern;
    bit         tamper;
    string      name;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  uart_sender #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .TX_EN     (tx_en),
    .TX_DATA   (tx_data),
    .TX_STATUS (tx_status),
    .UART_TX   (uart_tx)
  );

  uart_sender dut_def (
    .clk       (clk),
    .reset     (reset),
    .TX_EN     (tx_en2),
    .TX_DATA   (tx_data2),
    .TX_STATUS (tx_status2),
    .UART_TX   (uart_tx2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [0:9] pat,
                           input bit tamper, input string tag);
    int busy;
    int bad;
    tx_data = d;
    tx_en   = 1'b1;
    step();
    tx_en   = 1'b0;
    for (int k = 0; k < 161; k++) begin
      line_s[k] = uart_tx;
      stat_s[k] = tx_status;
      if (tamper && k == 40) begin
        tx_data = 8'hFF;
        tx_en   = 1'b1;
      end
      if (tamper && k == 41) tx_en = 1'b0;
      step();
    end
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int j = 0; j < 16; j++)
        if (line_s[16*b+j] !== pat[b]) bad++;
      check($sformatf("%s bit%0d wrong samples", tag, b), bad, 0);
    end
    busy = 0;
    for (int k = 0; k < 160; k++)
      if (stat_s[k] === 1'b1) busy++;
    check($sformatf("%s busy cycles", tag), busy, 160);
    check($sformatf("%s status after frame", tag), int'(stat_s[160]), 0);
    check($sformatf("%s line after frame", tag), int'(line_s[160]), 1);
    if (tamper) begin
      bad = 0;
      for (int k = 0; k < 40; k++) begin
        if (uart_tx !== 1'b1 || tx_status !== 1'b0) bad++;
        step();
      end
      check($sformatf("%s no second frame", tag), bad, 0);
    end
  endtask

  initial begin
    int bad;
    int cnt;

    vecs[0] = '{8'h55, 10'b0101010101, 1'b0, "x55"};
    vecs[1] = '{8'hA3, 10'b0110001011, 1'b1, "xA3_tamper"};
    vecs[2] = '{8'h0F, 10'b0111100001, 1'b0, "x0F"};
    vecs[3] = '{8'hFF, 10'b0111111111, 1'b0, "xFF"};
    vecs[4] = '{8'h00, 10'b0000000001, 1'b0, "x00"};

    reset    = 1'b1;
    tx_en    = 1'b0;
    tx_data  = 8'h00;
    tx_en2   = 1'b0;
    tx_data2 = 8'h00;
    #1;
    check("reset line", int'(uart_tx), 1);
    check("reset status", int'(tx_status), 0);
    step();
    step();
    check("reset line clocked", int'(uart_tx), 1);
    reset = 1'b0;

    bad = 0;
    for (int k = 0; k < 500; k++) begin
      if (uart_tx !== 1'b1 || tx_status !== 1'b0) bad++;
      step();
    end
    check("idle 500 cycles deviations", bad, 0);

    foreach (vecs[i])
      run_frame(vecs[i].data, vecs[i].pattern, vecs[i].tamper, vecs[i].name);

    // Reset at cycle 70 of a 0x55 frame, held 3 cycles.
    tx_data = 8'h55;
    tx_en   = 1'b1;
    step();
    tx_en   = 1'b0;
    repeat (70) step();
    check("pre-reset line mid-frame", int'(uart_tx), 0);
    reset = 1'b1;
    #1;
    check("reset mid-frame line immediate", int'(uart_tx), 1);
    check("reset mid-frame status immediate", int'(tx_status), 0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (uart_tx !== 1'b1 || tx_status !== 1'b0) bad++;
    end
    check("reset hold deviations", bad, 0);
    reset = 1'b0;
    run_frame(8'h81, 10'b0100000011, 1'b0, "x81_after_reset");

    // Back-to-back with TX_EN held high and data 0x00.
    tx_data = 8'h00;
    tx_en   = 1'b1;
    step();
    for (int k = 0; k < 483; k++) begin
      line_s[k] = uart_tx;
      stat_s[k] = tx_status;
      step();
    end
    tx_en = 1'b0;
    for (int f = 0; f < 3; f++) begin
      int base;
      base = f * 161;
      cnt = 0;
      for (int k = 0; k < 160; k++) if (stat_s[base+k] === 1'b1) cnt++;
      check($sformatf("b2b frame%0d busy cycles", f), cnt, 160);
      check($sformatf("b2b frame%0d idle gap status", f), int'(stat_s[base+160]), 0);
      cnt = 0;
      for (int k = 0; k < 144; k++) if (line_s[base+k] === 1'b0) cnt++;
      check($sformatf("b2b frame%0d low cycles", f), cnt, 144);
      cnt = 0;
      for (int k = 144; k < 160; k++) if (line_s[base+k] === 1'b1) cnt++;
      check($sformatf("b2b frame%0d stop high cycles", f), cnt, 16);
      if (f < 2) begin
        check($sformatf("b2b frame%0d next start line", f), int'(line_s[base+161]), 0);
        check($sformatf("b2b frame%0d next start status", f), int'(stat_s[base+161]), 1);
      end
    end
    cnt = 0;
    while (tx_status === 1'b1 && cnt < 400) begin
      step();
      cnt++;
    end
    check("b2b drains to idle", int'(tx_status), 0);

    // Default parameters: start bit must last 100000000/9600 = 10416 cycles.
    tx_data2 = 8'h0F;
    tx_en2   = 1'b1;
    step();
    tx_en2   = 1'b0;
    cnt = 0;
    while (uart_tx2 === 1'b0 && cnt < 20000) begin
      cnt++;
      step();
    end
    check("default start bit cycles", cnt, 10416);
    check("default first data bit", int'(uart_tx2), 1);
    check("default busy", int'(tx_status2), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_sender.md
UART_SENDER -- requirements
Module: uart_sender

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the line bit rate in bits/s.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port TX_EN, input, 1 bit: send request, sampled each rising clk edge.
REQ-006 SHALL have port TX_DATA, input, 8 bits: byte to send, captured at acceptance.
REQ-007 SHALL have port TX_STATUS, output, 1 bit: 1 = frame in progress (busy), 0 = idle.
REQ-008 SHALL have port UART_TX, output, 1 bit: serial line, idle-high.

Function
REQ-009 SHALL compute DIV = CLK_FREQ / BAUD, truncating integer division (100000000/9600 = 10416), with DIV >= 2.
REQ-010 SHALL send frame format 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-011 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-012 SHALL, in IDLE with TX_EN=1 at a rising edge, latch TX_DATA into a shift register and go to START; on the next cycle UART_TX=0 and TX_STATUS=1.
REQ-013 SHALL ignore TX_EN=0 in IDLE (stay IDLE, UART_TX=1, TX_STATUS=0).
REQ-014 SHALL ignore TX_EN while not IDLE: no queuing, and no effect on the current frame.
REQ-015 SHALL ignore TX_DATA changes after acceptance; the transmitted byte is the one latched at acceptance.
REQ-016 SHALL restart the baud counter at acceptance, so every bit, including the start bit, lasts exactly DIV clk cycles.
REQ-017 SHALL make the transitions START->DATA after DIV cycles, DATA->STOP after 8*DIV cycles (3-bit index wraps 7->0), and STOP->IDLE after DIV cycles.
REQ-018 SHALL hold TX_STATUS=1 for exactly 10*DIV cycles per frame, and UART_TX=1 during STOP.
REQ-019 SHALL drive TX_STATUS combinationally from state != IDLE, and drive UART_TX from a register (glitch-free).
REQ-020 SHALL accept, in the first cycle TX_STATUS reads 0 after a frame, a TX_EN=1 in that cycle, giving back-to-back frames with no idle gap beyond the stop bit.
REQ-021 SHALL size the baud counter at clog2(DIV) bits, compare it against DIV-1, and never let it overflow.

Reset
REQ-022 SHALL, while reset=1, immediately force state=IDLE, UART_TX=1, TX_STATUS=0, baud counter=0, bit index=0, shift register=0, independent of clk.
REQ-023 SHALL, on reset mid-frame, abort the frame with no completion; the line returns high at once.
REQ-024 SHALL, after reset deasserts, accept a TX_EN=1 at the first rising edge.

Structure
REQ-025 SHALL place state encodings (2-bit: IDLE=0, START=1, DATA=2, STOP=3), frame length 10 and data width 8 in the shared uart definitions package, for use with the future receiver.
REQ-026 SHALL implement the bit-period counter as sub-module uart_baud_tick (inputs clk, reset, clear; output tick pulsed once per DIV cycles).
REQ-027 SHALL have uart_sender contain only the FSM, shift register and line register.

Verification (CLK_FREQ=16, BAUD=1 -> DIV=16)
REQ-028 SHALL check: reset, then TX_EN pulse with TX_DATA=0x55 -> UART_TX sequence 0,1,0,1,0,1,0,1,0,1, each value held 16 cycles; TX_STATUS high exactly 160 cycles.
REQ-029 SHALL check: send 0xA3, change TX_DATA to 0xFF and pulse TX_EN at cycle 40 -> line still carries 0,1,1,0,0,0,1,0,1,1; no second frame.
REQ-030 SHALL check: TX_EN held high continuously with 0x00 -> back-to-back frames, each 160 cycles, stop bit exactly 16 cycles high, no extra idle cycles.
REQ-031 SHALL check: assert reset at cycle 70 of a frame for 3 cycles -> UART_TX=1 and TX_STATUS=0 within the same cycle; next TX_EN with 0x81 yields a clean, complete frame.
REQ-032 SHALL check: TX_EN=0 for 500 cycles after reset -> UART_TX constantly 1 and TX_STATUS constantly 0.
REQ-033 SHALL check the default parameters: one frame of 0x0F -> start bit lasts exactly 10416 cycles.
